// File: rtl/dla_common_pkg.sv
// dla_common_pkg: shared helpers for the dla blocks.
package dla_common_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dla_degroup_seq_pkg.sv
// dla_degroup_seq_pkg: sequencer state encoding and skew-line sizing.
package dla_degroup_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    // Stage 0 is group 0; the last group sits (GROUP_NUM-1)*GROUP_DELAY stages further down.
    function automatic int skew_depth(input int group_num, input int group_delay);
        return 1 + (group_num - 1) * group_delay;
    endfunction

endpackage

// File: rtl/dla_group_skew_line.sv
// dla_group_skew_line: resettable shift line turning one accept into staggered per-group write pulses.
module dla_group_skew_line
    import dla_degroup_seq_pkg::*;
#(
    parameter int GROUP_NUM   = 4,
    parameter int GROUP_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 i_aresetn,
    input  logic                 i_push,
    output logic [GROUP_NUM-1:0] o_group_valid,
    output logic                 o_empty,
    output logic                 o_last
);

    localparam int DEPTH = skew_depth(GROUP_NUM, GROUP_DELAY);

    logic [DEPTH-1:0] stage_q;

    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) stage_q <= '0;
        else            stage_q <= (stage_q << 1) | DEPTH'(i_push);
    end

    for (genvar g = 0; g < GROUP_NUM; g++) begin : g_tap
        assign o_group_valid[g] = stage_q[g*GROUP_DELAY];
    end

    assign o_empty = ~|stage_q;
    // Only the final stage may still be set, so the line empties on the next edge when nothing is pushed.
    assign o_last  = ~|(stage_q << 1);

endmodule

// File: rtl/dla_degroup_seq.sv
// dla_degroup_seq: burst sequencer admitting source transactions against downstream FIFO credits
// and issuing skewed per-group FIFO writes.
module dla_degroup_seq
    import dla_common_pkg::*;
    import dla_degroup_seq_pkg::*;
#(
    parameter int GROUP_NUM   = 4,
    parameter int GROUP_DELAY = 2,
    parameter int CREDITS     = GROUP_NUM * GROUP_DELAY + 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             i_aresetn,
    input  logic                             i_cfg_valid,
    output logic                             o_cfg_ready,
    input  logic [COUNT_WIDTH-1:0]           i_cfg_count,
    input  logic                             i_src_valid,
    output logic                             o_src_ready,
    output logic [GROUP_NUM-1:0]             o_group_valid,
    input  logic                             i_credit_return,
    output logic [clog2(CREDITS+1)-1:0]      o_outstanding,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int CW = clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    state_e                 state_q;
    logic [CW-1:0]          credits_q, credits_d, outstanding_q;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic                   done_q, accept, skew_empty, skew_last;

    assign o_cfg_ready   = state_q == IDLE;
    assign o_src_ready   = state_q == RUN && credits_q != '0;
    assign accept        = i_src_valid && o_src_ready;
    assign o_busy        = state_q != IDLE;
    assign o_done        = done_q;
    assign o_outstanding = outstanding_q;

    // Credits are taken at accept so entries still travelling the skew line stay reserved.
    always_comb
        credits_d = (accept && !i_credit_return) ? credits_q - CW'(1) :
                    (i_credit_return && !accept && credits_q != FULL) ? credits_q + CW'(1) : credits_q;

    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q       <= IDLE;
            credits_q     <= FULL;
            outstanding_q <= '0;
            remaining_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            credits_q     <= credits_d;
            outstanding_q <= FULL - credits_d;
            done_q        <= 1'b0;
            case (state_q)
                IDLE: if (i_cfg_valid) begin
                    if (i_cfg_count == '0) done_q <= 1'b1;
                    else begin
                        remaining_q <= i_cfg_count;
                        state_q     <= RUN;
                    end
                end
                RUN: if (accept) begin
                    remaining_q <= remaining_q - COUNT_WIDTH'(1);
                    if (remaining_q == COUNT_WIDTH'(1)) state_q <= DRAIN;
                end
                DRAIN: if (skew_last) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dla_group_skew_line #(
        .GROUP_NUM  (GROUP_NUM),
        .GROUP_DELAY(GROUP_DELAY)
    ) u_skew (
        .clk          (clk),
        .i_aresetn    (i_aresetn),
        .i_push       (accept),
        .o_group_valid(o_group_valid),
        .o_empty      (skew_empty),
        .o_last       (skew_last)
    );

    always @(posedge clk) begin
        if (i_aresetn) begin
            assert (!(i_credit_return && !accept && credits_q == FULL))
                else $error("credit return with all credits already held");
            assert (state_q != IDLE || skew_empty)
                else $error("group writes still in flight while idle");
        end
    end

endmodule

// File: tb/tb_dla_degroup_seq.sv
// tb_dla_degroup_seq: directed bench with a scoreboard of expected group pulses and done pulses.
module tb_dla_degroup_seq;

    localparam int GN = 4;
    localparam int GD = 2;
    localparam int CR = GN * GD + 3;

    logic        clk = 1'b0;
    logic        i_aresetn = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic [15:0] i_cfg_count = '0;
    logic        i_src_valid = 1'b0;
    logic        i_credit_return = 1'b0;
    logic        o_cfg_ready, o_src_ready, o_busy, o_done;
    logic [GN-1:0] o_group_valid;
    logic [3:0]  o_outstanding;

    dla_degroup_seq #(
        .GROUP_NUM(GN), .GROUP_DELAY(GD), .CREDITS(CR), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .i_aresetn(i_aresetn),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_count(i_cfg_count),
        .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
        .o_group_valid(o_group_valid), .i_credit_return(i_credit_return),
        .o_outstanding(o_outstanding), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int cyc, n_tests, n_fail;
    int m_st, m_credits = CR, m_rem, m_done_at;
    int gq[GN][$];
    int dq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Check the current cycle against the model, then advance the model and the clock.
    task automatic tick();
        bit exp_g, exp_d, acc;
        int st0;
        st0 = m_st;
        chk("src_ready", o_src_ready, st0 == 1 && m_credits != 0);
        chk("cfg_ready", o_cfg_ready, st0 == 0);
        chk("busy", o_busy, st0 != 0);
        chk("outstanding", o_outstanding, CR - m_credits);
        for (int g = 0; g < GN; g++) begin
            exp_g = gq[g].size() != 0 && gq[g][0] == cyc;
            chk($sformatf("group%0d", g), o_group_valid[g], exp_g);
            if (exp_g) void'(gq[g].pop_front());
        end
        exp_d = dq.size() != 0 && dq[0] == cyc;
        chk("done", o_done, exp_d);
        if (exp_d) void'(dq.pop_front());
        acc = i_src_valid && st0 == 1 && m_credits != 0;
        if (st0 == 2 && cyc + 1 == m_done_at) m_st = 0;
        if (acc) begin
            for (int g = 0; g < GN; g++) gq[g].push_back(cyc + 1 + g * GD);
            m_rem--;
            if (m_rem == 0) begin
                m_done_at = cyc + 2 + (GN - 1) * GD;
                dq.push_back(m_done_at);
                m_st = 2;
            end
        end else if (i_cfg_valid && st0 == 0) begin
            if (i_cfg_count == 0) dq.push_back(cyc + 1);
            else begin
                m_st  = 1;
                m_rem = int'(i_cfg_count);
            end
        end
        if (acc && !i_credit_return) m_credits--;
        else if (i_credit_return && !acc && m_credits < CR) m_credits++;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (o_done !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        chk("done_seen", o_done, 1'b1);
    endtask

    task automatic drain_credits();
        int k;
        k = 0;
        i_src_valid = 1'b0;
        while (m_credits != CR && k < 2 * CR) begin
            i_credit_return = 1'b1;
            tick();
            k++;
        end
        i_credit_return = 1'b0;
        chk("credits_drained", o_outstanding, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_group", o_group_valid, 0);
        chk("rst_done", o_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_outstanding", o_outstanding, 0);
        chk("rst_cfg_ready", o_cfg_ready, 1);
        i_aresetn = 1'b1;
        run(2);

        // Three back-to-back accepts, no returns.
        i_cfg_valid = 1'b1; i_cfg_count = 16'd3;
        tick();
        i_cfg_valid = 1'b0; i_src_valid = 1'b1;
        run(3);
        i_src_valid = 1'b0;
        wait_done(20);
        chk("t1_busy_at_done", o_busy, 0);
        tick();
        drain_credits();

        // Credit exhaustion and recovery.
        i_cfg_valid = 1'b1; i_cfg_count = 16'd20;
        tick();
        i_cfg_valid = 1'b0; i_src_valid = 1'b1;
        run(14);
        chk("t2_stall_ready", o_src_ready, 0);
        chk("t2_stall_outstanding", o_outstanding, 11);
        i_src_valid = 1'b0; i_credit_return = 1'b1;
        tick();
        i_credit_return = 1'b0; i_src_valid = 1'b1;
        chk("t2_ready_after_return", o_src_ready, 1);
        tick();
        i_src_valid = 1'b0; i_credit_return = 1'b1;
        run(5);
        chk("t3_pre_outstanding", o_outstanding, 6);
        i_src_valid = 1'b1;
        tick();
        chk("t3_both_outstanding", o_outstanding, 6);
        run(7);
        i_src_valid = 1'b0; i_credit_return = 1'b0;
        wait_done(30);
        tick();
        drain_credits();

        // Zero-length burst.
        i_cfg_valid = 1'b1; i_cfg_count = 16'd0;
        tick();
        i_cfg_valid = 1'b0;
        chk("t4_done", o_done, 1);
        chk("t4_busy", o_busy, 0);
        tick();
        chk("t4_done_single", o_done, 0);
        run(3);

        // Reset after 2 of 5 accepts.
        i_cfg_valid = 1'b1; i_cfg_count = 16'd5;
        tick();
        i_cfg_valid = 1'b0; i_src_valid = 1'b1;
        run(2);
        i_src_valid = 1'b0;
        i_aresetn = 1'b0;
        #1;
        chk("t5_group", o_group_valid, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_outstanding", o_outstanding, 0);
        chk("t5_done", o_done, 0);
        chk("t5_src_ready", o_src_ready, 0);
        for (int g = 0; g < GN; g++) gq[g].delete();
        dq.delete();
        m_st = 0; m_credits = CR; m_rem = 0;
        @(posedge clk);
        cyc++;
        #1;
        i_aresetn = 1'b1;
        run(10);

        // Config held during a burst is taken only once idle again.
        i_cfg_valid = 1'b1; i_cfg_count = 16'd2;
        tick();
        i_cfg_count = 16'd7; i_src_valid = 1'b1;
        run(2);
        i_src_valid = 1'b0;
        chk("t6_cfg_blocked", o_cfg_ready, 0);
        wait_done(20);
        chk("t6_cfg_ready_at_done", o_cfg_ready, 1);
        tick();
        i_cfg_valid = 1'b0;
        chk("t6_busy_new", o_busy, 1);
        i_src_valid = 1'b1;
        run(7);
        i_src_valid = 1'b0;
        wait_done(30);
        tick();
        drain_credits();
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
